// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Multiply is radix-2 shift-add, divide is restoring division, both on
// operand magnitudes with a sign fixup in the final FIX state.
// Optional build macro MULDIV_FAST_MULT_EN: multiplies bypass RUN and use a
// single-cycle multiplier; divides keep the 33-cycle iterative path.
`timescale 1ns/1ps
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;

    // Operation context captured at issue
    logic        is_div;
    logic        neg_q;     // product / quotient must be negated
    logic        neg_r;     // remainder must be negated (dividend was negative)
    logic [63:0] acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] b;         // multiplicand or divisor magnitude

    logic        signed_op;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    logic [32:0] mul_sum;
    logic [32:0] div_tmp;
    logic [31:0] div_sub;
    logic        div_ge;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Two's-complement magnitude of a 32-bit operand when treated as signed
    function automatic logic [31:0] magnitude(input logic [31:0] val, input logic is_signed);
        logic signed [31:0] v;
        v = $signed(val);
        if (is_signed && v < 0)
            v = -v;
        return $unsigned(v);
    endfunction

    // Conditional negation of a 32-bit result
    function automatic logic [31:0] sign_fix32(input logic [31:0] mag, input logic neg);
        logic signed [31:0] v;
        v = $signed(mag);
        if (neg)
            v = -v;
        return $unsigned(v);
    endfunction

    // Conditional negation of a 64-bit product
    function automatic logic [63:0] sign_fix64(input logic [63:0] mag, input logic neg);
        logic signed [63:0] v;
        v = $signed(mag);
        if (neg)
            v = -v;
        return $unsigned(v);
    endfunction

    assign signed_op = ~op[0];
    assign rs_mag    = magnitude(rs_val, signed_op);
    assign rt_mag    = magnitude(rt_val, signed_op);

    // One shift-add step: add multiplicand when multiplier LSB is set, then shift right
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : 33'd0);

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    // When the subtraction fits the true difference is below 2^32, so 32 bits suffice.
    assign div_tmp = {acc[63:32], acc[31]};
    assign div_ge  = (div_tmp >= {1'b0, b});
    assign div_sub = div_tmp[31:0] - b;

    // Final results; a zero divisor forces an all-ones quotient, while the remainder
    // path naturally reproduces the issued dividend (magnitude with dividend sign)
    assign prod_fix = sign_fix64(acc, neg_q);
    assign quo_fix  = (b == 32'd0) ? 32'hFFFF_FFFF : sign_fix32(acc[31:0], neg_q);
    assign rem_fix  = sign_fix32(acc[63:32], neg_r);

    assign busy = (state != IDLE);

`ifdef MULDIV_FAST_MULT_EN
    logic signed [63:0] fast_a;
    logic signed [63:0] fast_b;
    logic        [63:0] fast_prod;

    assign fast_a    = op[0] ? $signed({32'd0, rs_val}) : $signed({{32{rs_val[31]}}, rs_val});
    assign fast_b    = op[0] ? $signed({32'd0, rt_val}) : $signed({{32{rt_val[31]}}, rt_val});
    assign fast_prod = $unsigned(fast_a * fast_b);
`endif

    // State register, iteration counter and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FIX);
            if (state == IDLE && start)
                cnt <= 6'd0;
            else if (state == RUN)
                cnt <= cnt + 6'd1;
        end
    end

    // Next-state decode: 32 RUN iterations then a single FIX cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_nxt = op[1] ? RUN : FIX;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt == 6'd31)
                    state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture operands at issue and iterate while in RUN
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    is_div <= op[1];
                    neg_q  <= signed_op & (rs_val[31] ^ rt_val[31]);
                    neg_r  <= signed_op & rs_val[31];
                    if (op[1]) begin
                        acc <= {32'd0, rs_mag};
                        b   <= rt_mag;
                    end else begin
`ifdef MULDIV_FAST_MULT_EN
                        acc   <= fast_prod;
                        neg_q <= 1'b0;
`else
                        acc   <= {32'd0, rt_mag};
`endif
                        b     <= rs_mag;
                    end
                end
            end
            RUN: begin
                if (is_div)
                    acc <= {(div_ge ? div_sub : div_tmp[31:0]), acc[30:0], div_ge};
                else
                    acc <= {mul_sum, acc[31:1]};
            end
            default: begin
            end
        endcase
    end

    // Architectural HI/LO: operation results in FIX, moves only when idle and not issuing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (is_div) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end else begin
                hi <= prod_fix[63:32];
                lo <= prod_fix[31:0];
            end
        end else if (state == IDLE && !start) begin
            if (mthi)
                hi <= rs_val;
            if (mtlo)
                lo <= rs_val;
        end
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes operand values and a decoded mul/div operation issued from EX and owns the architectural HI/LO registers. It computes MULT/MULTU as 64-bit products and DIV/DIVU as quotient and remainder. It raises `busy` so the hazard unit stalls IF/ID and flushes ID/EX while an operation is in flight.

## Interface
Parameters:
- `XLEN`, 32, operand width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  issue the operation selected by `op`; valid only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  multiplicand / dividend, from the EX forwarding mux.
- `rt_val`  in  32  multiplier / divisor.
- `mthi`  in  1  write `rs_val` into HI.
- `mtlo`  in  1  write `rs_val` into LO.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  high while an operation is in flight; the hazard unit stalls on it.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are written by an operation.

## Operation
- States: IDLE, RUN, FIX. `busy` = (state != IDLE), decoded from registers.
- IDLE:
  - If `start`:
    - Latch the operands. For signed ops (00, 10), latch magnitudes and record the result signs.
    - Clear the 6-bit iteration counter and go to RUN.
  - Else if `mthi`/`mtlo`: write `rs_val` to HI/LO. Both may be written in the same cycle.
  - `start` has priority over `mthi`/`mtlo` in the same cycle; the moves are dropped.
- RUN: one iteration per cycle, 32 iterations, then go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator, unsigned on the magnitudes.
  - Divide: restoring division producing a 32-bit quotient and a 32-bit remainder, unsigned on the magnitudes.
- FIX:
  - Apply sign fixup:
    - Signed product: negated if the operand signs differ.
    - Signed quotient: negated if the operand signs differ.
    - Signed remainder: takes the sign of the dividend.
  - Write results: product → {HI,LO}; quotient → LO, remainder → HI.
  - Return to IDLE. Set `done` for the following cycle.
- Divide by zero (either signedness): LO = 32'hFFFF_FFFF, HI = `rs_val` as issued. Full latency still applies.
- Signed overflow, 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- `start`, `mthi` and `mtlo` are ignored while `busy`. The hazard unit guarantees that stalled instructions are re-presented.
- MFHI/MFLO read `hi`/`lo` combinationally. The hazard unit must stall them while `busy`; this block does not forward in-flight results.

## Timing
- Reset (asynchronous, any state): state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, counter = 0.
  - Reset mid-operation abandons the operation; HI/LO end at 0.
- `start` is sampled at edge E0:
  - `busy` is high from after E0 through the cycle ending at E33 (33 cycles).
  - RUN spans edges E1..E32.
  - HI/LO are written at E33, and `done` is high for the cycle E33–E34.
- `start` asserted in the cycle `done` is high is accepted; back-to-back operations issue every 34 cycles.
- `mthi`/`mtlo` update at the sampling edge; the new value is visible on `hi`/`lo` the next cycle.
- `done` is never asserted for `mthi`/`mtlo`.

## Configuration
- `MULDIV_FAST_MULT_EN`:
  - Defined: MULT/MULTU skip RUN. IDLE→FIX computes the 64-bit signed/unsigned product with a single-cycle multiplier. HI/LO are written at E1, `busy` is high for 1 cycle and `done` is high for E1–E2. Divides are unchanged.
  - Undefined: all four ops use the 33-cycle iterative path.

## Test plan
- Reset mid-op: issue DIVU, deassert `rst_n` at E10 → `busy` = 0, `hi` = `lo` = 0 immediately; a subsequent MULTU 3×5 gives LO = 15.
- MULT 32'hFFFF_FFFE × 32'h0000_0003 → HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFA at E33 (E1 with `MULDIV_FAST_MULT_EN`); `busy` has the stated length.
- DIV 32'hFFFF_FFF9 (−7) / 2 → LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF. DIVU 100/7 → LO = 14, HI = 2.
- DIVU 1234 / 0 → LO = 32'hFFFF_FFFF, HI = 1234. DIV 32'h8000_0000 / 32'hFFFF_FFFF → LO = 32'h8000_0000, HI = 0.
- With `start` + `mthi` in the same IDLE cycle, the multiply result is kept. `mtlo` of 32'hA5A5_A5A5 pulsed while busy leaves LO equal to the operation result.
- `start` held continuously → second operation accepted exactly at the `done` cycle; `done` pulses exactly once per operation.
